// File: rtl/rpi_readout_pkg.sv
// Shared types and constants for the RPi readout bridge.
package qn_readout_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;

  localparam logic [WORD_W-1:0] TRAILER_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/rpi_readout_if.sv
// FIFO read-port bundle between the event FIFO (slave) and the readout bridge (master).
interface rpi_readout_if;
  import qn_readout_pkg::*;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_valid;
  logic              fifo_empty;
  logic              fifo_rd_en;

  modport master (
    input  fifo_dout,
    input  fifo_valid,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_dout,
    output fifo_valid,
    output fifo_empty,
    input  fifo_rd_en
  );

endinterface

// File: rtl/rpi_readout_edge_sync.sv
// Synchronizer + debounce filter for one asynchronous strobe, with registered
// single-cycle rise/fall pulses on changes of the filtered level.
module edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 2
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // cnt_q counts consecutive synchronized samples that disagree with the
  // filtered level; the level flips on the DEBOUNCE-th such sample.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge
      // values, which is what turns this shift into a real synchronizer chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_lvl == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_lvl;
        rise_q  <= sync_lvl;
        fall_q  <= ~sync_lvl;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/rpi_readout.sv
// Readout bridge: pops one FIFO word per accepted rd_clk rise and presents it
// to the RPi on otube with a level rd_valid, plus debug counters and error flags.
module rpi_readout
  import qn_readout_pkg::*;
#(
  parameter int                SYNC_STAGES   = 2,
  parameter int                DEBOUNCE      = 2,
  parameter int                VALID_TIMEOUT = 4,
  parameter logic [WORD_W-1:0] TRAILER_WORD  = qn_readout_pkg::TRAILER_WORD
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              rd_clk,
  input  logic              rd_en,
  rpi_readout_if.master     fifo,
  output logic [WORD_W-1:0] otube,
  output logic              rd_valid,
  output logic              rd_empty,
  output logic [CNT_W-1:0]  words_sent,
  output logic [CNT_W-1:0]  events_sent,
  output logic              err_protocol,
  output logic              err_timeout
);

  localparam int TMO_W = $clog2(VALID_TIMEOUT + 1);

  logic clk_level, clk_rise, clk_fall;
  logic en_level, en_rise, en_fall;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_clk_sync (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .async_i (rd_clk),
    .level_o (clk_level),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_en_sync (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .async_i (rd_en),
    .level_o (en_level),
    .rise_o  (en_rise),
    .fall_o  (en_fall)
  );

  // Only the strobe edges and the enable level drive the FSM.
  logic unused_edges;
  assign unused_edges = clk_level ^ en_rise ^ en_fall;

  state_e            state_q;
  logic              fifo_rd_en_q;
  logic [WORD_W-1:0] otube_q;
  logic              rd_valid_q;
  logic              rd_empty_q;
  logic [CNT_W-1:0]  words_q;
  logic [CNT_W-1:0]  events_q;
  logic              err_protocol_q;
  logic              err_timeout_q;
  logic [TMO_W-1:0]  tmo_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      fifo_rd_en_q   <= 1'b0;
      otube_q        <= '0;
      rd_valid_q     <= 1'b0;
      rd_empty_q     <= 1'b1;
      words_q        <= '0;
      events_q       <= '0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      tmo_q          <= '0;
    end else begin
      fifo_rd_en_q <= 1'b0;
      rd_empty_q   <= fifo.fifo_empty;
      unique case (state_q)
        S_IDLE: begin
          if (clk_rise && en_level && !fifo.fifo_empty) begin
            fifo_rd_en_q <= 1'b1;
            state_q      <= S_POP;
          end
        end
        S_POP: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo.fifo_valid) begin
            otube_q    <= fifo.fifo_dout;
            rd_valid_q <= 1'b1;
            words_q    <= words_q + 1'b1;
            if (fifo.fifo_dout == TRAILER_WORD) events_q <= events_q + 1'b1;
            state_q    <= S_HOLD;
          end else if (tmo_q == TMO_W'(VALID_TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_HOLD: begin
          // The word stays valid until the RPi drops rd_clk; rd_en is irrelevant here.
          if (clk_fall) begin
            rd_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else if (clk_rise) begin
            err_protocol_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo.fifo_rd_en = fifo_rd_en_q;
  assign otube           = otube_q;
  assign rd_valid        = rd_valid_q;
  assign rd_empty        = rd_empty_q;
  assign words_sent      = words_q;
  assign events_sent     = events_q;
  assign err_protocol    = err_protocol_q;
  assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_rpi_readout.sv
// Self-checking bench for rpi_readout: an event-level model predicts every output
// each cycle, and directed scenarios pin latencies and values by hand.
`timescale 1ns/1ps
module tb_rpi_readout;
  import qn_readout_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 2;
  localparam int TO   = 4;
  localparam int WIN  = SYNC + DEB;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_clk = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] otube, words_sent, events_sent;
  logic        rd_valid, rd_empty, err_protocol, err_timeout;

  rpi_readout_if fifo_if ();

  rpi_readout #(
    .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .VALID_TIMEOUT(TO), .TRAILER_WORD(16'hFFFF)
  ) dut (
    .clk50        (clk50),
    .rst_n        (rst_n),
    .rd_clk       (rd_clk),
    .rd_en        (rd_en),
    .fifo         (fifo_if),
    .otube        (otube),
    .rd_valid     (rd_valid),
    .rd_empty     (rd_empty),
    .words_sent   (words_sent),
    .events_sent  (events_sent),
    .err_protocol (err_protocol),
    .err_timeout  (err_timeout)
  );

  always #10 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO stand-in: valid one cycle after a pop ----------------
  logic [15:0] mem [0:15];
  int          wr_ptr  = 0;
  int          rd_ptr  = 0;
  int          pop_cnt = 0;
  bit          stall   = 1'b0;

  task automatic load(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  initial forever begin
    int rp;
    @(posedge clk50);
    rp = rd_ptr;
    fifo_if.fifo_valid <= 1'b0;
    if (fifo_if.fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (rp != wr_ptr) begin
        fifo_if.fifo_dout  <= mem[rp];
        fifo_if.fifo_valid <= !stall;
        rp++;
      end
    end
    rd_ptr <= rp;
    fifo_if.fifo_empty <= (rp == wr_ptr);
  end

  // ---------------- Event-level model ----------------
  // A filtered level flips once the DEB samples that have just cleared the
  // SYNC-deep synchronizer all disagree with it; the transaction engine then
  // reacts one edge later.
  bit          hc[$], he[$];
  bit          lvl_c, lvl_e, rise_p, fall_p, force_rise;
  bit          m_busy, m_hold;
  int          m_pop, edge_n;
  logic [15:0] e_otube, e_words, e_events;
  bit          e_pop, e_valid, e_empty, e_errp, e_errt;

  function automatic bit window_flips(input bit q[$], input bit lvl);
    for (int i = 0; i < DEB; i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    bit r;
    @(posedge clk50 or negedge rst_n);
    if (!rst_n) begin
      hc.delete(); he.delete();
      for (int i = 0; i < WIN; i++) begin hc.push_back(1'b0); he.push_back(1'b0); end
      lvl_c = 0; lvl_e = 0; rise_p = 0; fall_p = 0;
      m_busy = 0; m_hold = 0; m_pop = 0; edge_n = 0;
      e_otube = 0; e_words = 0; e_events = 0;
      e_pop = 0; e_valid = 0; e_empty = 1; e_errp = 0; e_errt = 0;
    end else begin
      edge_n++;
      e_pop   = 0;
      e_empty = fifo_if.fifo_empty;
      r = rise_p | force_rise;
      if (m_hold) begin
        if (fall_p) begin m_hold = 0; e_valid = 0; end
        else if (r) e_errp = 1;
      end else if (m_busy) begin
        if (edge_n >= m_pop + 2) begin
          if (fifo_if.fifo_valid) begin
            e_otube = fifo_if.fifo_dout;
            e_valid = 1;
            e_words++;
            if (fifo_if.fifo_dout == 16'hFFFF) e_events++;
            m_busy = 0; m_hold = 1;
          end else if (edge_n == m_pop + 1 + TO) begin
            e_errt = 1; m_busy = 0;
          end
        end
      end else if (r && lvl_e && !fifo_if.fifo_empty) begin
        e_pop = 1; m_busy = 1; m_pop = edge_n;
      end
      hc.push_back(rd_clk); void'(hc.pop_front());
      he.push_back(rd_en);  void'(he.pop_front());
      rise_p = 0; fall_p = 0;
      if (window_flips(hc, lvl_c)) begin lvl_c = !lvl_c; rise_p = lvl_c; fall_p = !lvl_c; end
      if (window_flips(he, lvl_e)) lvl_e = !lvl_e;
    end
  end

  // ---------------- Per-cycle compare against the model ----------------
  initial forever begin
    @(negedge clk50);
    if (rst_n) begin
      check("cyc fifo_rd_en",   fifo_if.fifo_rd_en, e_pop);
      check("cyc otube",        otube,        e_otube);
      check("cyc rd_valid",     rd_valid,     e_valid);
      check("cyc rd_empty",     rd_empty,     e_empty);
      check("cyc words_sent",   words_sent,   e_words);
      check("cyc events_sent",  events_sent,  e_events);
      check("cyc err_protocol", err_protocol, e_errp);
      check("cyc err_timeout",  err_timeout,  e_errt);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return rd_valid;
      1:       return fifo_if.fifo_rd_en;
      default: return err_timeout;
    endcase
  endfunction

  // Clock edges until the selected output shows `want`; 999 if it never does.
  task automatic wait_sig(input int sel, input logic want, output int n);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk50);
      if (sig(sel) == want) begin n = i; return; end
    end
    n = 999;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " otube"},        otube,              16'h0);
    check({tag, " rd_valid"},     rd_valid,           1'b0);
    check({tag, " rd_empty"},     rd_empty,           1'b1);
    check({tag, " fifo_rd_en"},   fifo_if.fifo_rd_en, 1'b0);
    check({tag, " words_sent"},   words_sent,         16'h0);
    check({tag, " events_sent"},  events_sent,        16'h0);
    check({tag, " err_protocol"}, err_protocol,       1'b0);
    check({tag, " err_timeout"},  err_timeout,        1'b0);
  endtask

  // 400 ns high / 400 ns low rd_clk pulse, measuring both rd_valid latencies.
  task automatic clean_pulse(input logic [15:0] exp_word);
    int n;
    @(negedge clk50);
    rd_clk = 1'b1;
    wait_sig(0, 1'b1, n);
    check("rise-to-valid latency", n, 7);
    check("delivered word", otube, exp_word);
    cycles(20 - n);
    rd_clk = 1'b0;
    wait_sig(0, 1'b0, n);
    check("fall-to-clear latency", n, 5);
    cycles(20 - n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    force_rise = 1'b0;
    load(16'h1203); load(16'h0823); load(16'hFFFF);

    // Reset values
    cycles(3);
    check_reset_values("reset");
    @(negedge clk50);
    rst_n = 1'b1;
    rd_en = 1'b1;
    cycles(10);

    // Three clean reads
    clean_pulse(16'h1203);
    clean_pulse(16'h0823);
    clean_pulse(16'hFFFF);
    check("words after 3 reads",  words_sent,  16'd3);
    check("events after 3 reads", events_sent, 16'd1);

    // Read attempt on an empty FIFO
    check("rd_empty when drained", rd_empty, 1'b1);
    p0 = pop_cnt;
    @(negedge clk50); rd_clk = 1'b1;
    cycles(20);
    check("empty read rd_valid", rd_valid, 1'b0);
    rd_clk = 1'b0;
    cycles(20);
    check("empty read pops", pop_cnt - p0, 0);
    check("empty read rd_empty", rd_empty, 1'b1);

    // One-cycle glitch on rd_clk
    load(16'h0A55); load(16'h1234);
    cycles(3);
    p0 = pop_cnt;
    @(negedge clk50); rd_clk = 1'b1;
    @(negedge clk50); rd_clk = 1'b0;
    cycles(12);
    check("glitch pops",  pop_cnt - p0, 0);
    check("glitch words", words_sent, 16'd3);

    // Second rise while holding a word
    p0 = pop_cnt;
    @(negedge clk50); rd_clk = 1'b1;
    wait_sig(0, 1'b1, n);
    check("hold rise-to-valid latency", n, 7);
    check("hold word", otube, 16'h0A55);
    cycles(3);
    @(negedge clk50);
    force dut.clk_rise = 1'b1;
    force_rise = 1'b1;
    @(negedge clk50);
    release dut.clk_rise;
    force_rise = 1'b0;
    cycles(3);
    check("protocol error flag", err_protocol, 1'b1);
    check("protocol single pop", pop_cnt - p0, 1);
    check("protocol rd_valid kept", rd_valid, 1'b1);
    rd_clk = 1'b0;
    wait_sig(0, 1'b0, n);
    check("protocol fall-to-clear", n, 5);
    cycles(10);

    // fifo_valid never arrives
    stall = 1'b1;
    p0 = pop_cnt;
    @(negedge clk50); rd_clk = 1'b1;
    wait_sig(1, 1'b1, n);
    check("rise-to-pop latency", n, 5);
    wait_sig(2, 1'b1, n);
    check("pop-to-timeout latency", n, 5);
    check("timeout rd_valid", rd_valid, 1'b0);
    check("timeout single pop", pop_cnt - p0, 1);
    cycles(5);
    rd_clk = 1'b0;
    cycles(12);

    // Reset asserted while waiting for data
    load(16'h0BEE); load(16'h0C0C);
    cycles(3);
    @(negedge clk50); rd_clk = 1'b1;
    wait_sig(1, 1'b1, n);
    check("pre-reset pop latency", n, 5);
    @(negedge clk50);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async reset");
    rd_clk = 1'b0;
    stall  = 1'b0;
    cycles(3);
    @(negedge clk50); rst_n = 1'b1;
    p0 = pop_cnt;
    cycles(12);
    check("post-reset spurious pops", pop_cnt - p0, 0);
    clean_pulse(16'h0C0C);
    check("post-reset words",  words_sent,  16'd1);
    check("post-reset events", events_sent, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
